ddfs_controller: RTL and testbench

Sequencer for the `ddfs_sine_lut` quadrature table in the lock-in reference path. It owns a phase accumulator advanced by a per-sample strobe and drives the LUT address with a programmable phase offset. Frequency tuning words arrive over a valid/ready handshake and are committed phase-continuously at accumulator wrap. It emits registered sine/cosine reference samples with a valid strobe to the lock-in mixers.

---
 rtl/lockin_pkg.sv | 63 ++++++
 rtl/ddfs_controller_if.sv | 30 +++
 rtl/ddfs_sine_lut.sv | 35 +++
 rtl/ddfs_controller.sv | 168 ++++++++++++++++
 tb/tb_ddfs_controller.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lockin_pkg.sv
// lockin_pkg: shared definitions for the lock-in reference DDFS path.
//   - Default widths for the phase accumulator and the sine/cosine table.
//   - Controller state encoding (ST_IDLE, ST_RUN, ST_PEND).
//   - lut_sample(): integer-only sine generator used to fill the quadrature
//     table at elaboration time, so the ROM needs no external init file.
package lockin_pkg;

    localparam int DEF_ACC_BITS  = 32;
    localparam int DEF_LUT_DEPTH = 10;
    localparam int DEF_LUT_BITS  = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam longint ONE_Q30 = longint'(1) <<< 30;
    localparam longint PI_Q30  = 64'sd3373259426;  // pi * 2^30

    // sin(k * (pi/2) / 2^(depth-2)) in Q30, k in [0, 2^(depth-2)].
    // Taylor series up to x^9 in Horner form; truncation error stays well
    // below one LSB of an 18-bit sample over the first quadrant.
    function automatic longint quarter_sin_q30(input longint k, input int depth);
        longint x;
        longint x2;
        longint t;
        x  = (PI_Q30 * k) >>> (depth - 1);
        x2 = (x * x) >>> 30;
        t  = ONE_Q30 - x2 / 72;
        t  = ONE_Q30 - ((x2 * t) >>> 30) / 42;
        t  = ONE_Q30 - ((x2 * t) >>> 30) / 20;
        t  = ONE_Q30 - ((x2 * t) >>> 30) / 6;
        return (x * t) >>> 30;
    endfunction

    // Full-cycle signed sine sample for table address addr, amplitude
    // 2^(bits-1)-1, built from the first quadrant by symmetry.
    function automatic int lut_sample(input int addr, input int depth, input int bits);
        int     quarter;
        int     q;
        int     idx;
        int     k;
        longint s;
        longint amp;
        longint v;
        quarter = 1 << (depth - 2);
        q       = (addr >> (depth - 2)) & 3;
        idx     = addr & (quarter - 1);
        k       = q[0] ? (quarter - idx) : idx;
        s       = quarter_sin_q30(longint'(k), depth);
        amp     = (longint'(1) <<< (bits - 1)) - 1;
        v       = (s * amp + (longint'(1) <<< 29)) >>> 30;
        if (v > amp) begin
            v = amp;
        end
        if (q[1]) begin
            v = -v;
        end
        return int'(v);
    endfunction

endpackage

// File: rtl/ddfs_controller_if.sv
// ddfs_controller_if: tuning-word transfer channel into ddfs_controller.
//   ftw_data  : frequency tuning word (unsigned, ACC_BITS wide)
//   ftw_valid : word offered by the master
//   ftw_ready : controller can take a word
// Handshake: a word transfers on a rising edge where ftw_valid && ftw_ready.
// The master keeps ftw_data stable while ftw_valid is high and ftw_ready is
// low; ftw_ready is a registered function of controller state only.
interface ddfs_controller_if
    import lockin_pkg::*;
#(
    parameter int ACC_BITS = DEF_ACC_BITS
);

    logic [ACC_BITS-1:0] ftw_data;
    logic                ftw_valid;
    logic                ftw_ready;

    modport master (
        output ftw_data,
        output ftw_valid,
        input  ftw_ready
    );

    modport slave (
        input  ftw_data,
        input  ftw_valid,
        output ftw_ready
    );

endinterface

// File: rtl/ddfs_sine_lut.sv
// ddfs_sine_lut: quadrature sine/cosine table with a 1-cycle registered read.
//   clk        : rising-edge clock
//   addr       : phase address, 2^LUT_DEPTH entries per full cycle
//   sine_out   : signed sin(2*pi*addr/2^LUT_DEPTH), registered
//   cosine_out : signed cos(2*pi*addr/2^LUT_DEPTH), registered
module ddfs_sine_lut
    import lockin_pkg::*;
#(
    parameter int LUT_DEPTH = DEF_LUT_DEPTH,
    parameter int LUT_BITS  = DEF_LUT_BITS
) (
    input  logic                       clk,
    input  logic [LUT_DEPTH-1:0]       addr,
    output logic signed [LUT_BITS-1:0] sine_out,
    output logic signed [LUT_BITS-1:0] cosine_out
);

    localparam int ENTRIES = 1 << LUT_DEPTH;
    localparam int QUARTER = 1 << (LUT_DEPTH - 2);

    logic signed [LUT_BITS-1:0] sin_rom [ENTRIES];
    logic signed [LUT_BITS-1:0] cos_rom [ENTRIES];

    // Cosine is the sine table read a quarter cycle ahead.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_rom
        assign sin_rom[i] = LUT_BITS'(lut_sample(i, LUT_DEPTH, LUT_BITS));
        assign cos_rom[i] = LUT_BITS'(lut_sample((i + QUARTER) % ENTRIES, LUT_DEPTH, LUT_BITS));
    end

    always_ff @(posedge clk) begin
        sine_out   <= sin_rom[addr];
        cosine_out <= cos_rom[addr];
    end

endmodule

// File: rtl/ddfs_controller.sv
// ddfs_controller: phase-accumulator sequencer for the quadrature LUT.
//   clk, rst    : clock and synchronous active-high reset
//   enable      : run request (level)
//   sample_tick : one-cycle advance strobe
//   ftw_if      : tuning-word handshake (slave side)
//   phase_off   : LUT address offset, sampled with each accepted tick
//   sync_clear  : one-cycle strobe, zeroes the accumulator
//   sine_out, cosine_out : registered signed samples, held between strobes
//   out_valid   : new sample pair, 3 cycles after the tick
//   wrap        : accumulator carry-out, 1 cycle after the tick
//   running     : high in RUN or PEND
//   state_dbg   : current FSM state
module ddfs_controller
    import lockin_pkg::*;
#(
    parameter int ACC_BITS  = DEF_ACC_BITS,
    parameter int LUT_DEPTH = DEF_LUT_DEPTH,
    parameter int LUT_BITS  = DEF_LUT_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       sample_tick,
    ddfs_controller_if.slave           ftw_if,
    input  logic [LUT_DEPTH-1:0]       phase_off,
    input  logic                       sync_clear,
    output logic signed [LUT_BITS-1:0] sine_out,
    output logic signed [LUT_BITS-1:0] cosine_out,
    output logic                       out_valid,
    output logic                       wrap,
    output logic                       running,
    output state_t                     state_dbg
);

    state_t                     state_q;
    logic [ACC_BITS-1:0]        acc_q;
    logic [ACC_BITS-1:0]        ftw_q;
    logic [ACC_BITS-1:0]        shadow_q;
    logic [LUT_DEPTH-1:0]       addr_q;
    logic                       v1_q;
    logic                       v2_q;
    logic                       out_valid_q;
    logic                       wrap_q;
    logic                       running_q;
    logic                       ftw_ready_q;
    logic signed [LUT_BITS-1:0] sine_q;
    logic signed [LUT_BITS-1:0] cosine_q;

    logic signed [LUT_BITS-1:0] lut_sine;
    logic signed [LUT_BITS-1:0] lut_cosine;

    logic                       accept;
    logic [ACC_BITS:0]          acc_sum;
    logic                       carry;
    logic [LUT_DEPTH-1:0]       tick_addr;

    assign accept    = ftw_if.ftw_valid && ftw_ready_q;
    assign acc_sum   = {1'b0, acc_q} + {1'b0, ftw_q};
    assign carry     = acc_sum[ACC_BITS];
    assign tick_addr = acc_q[ACC_BITS-1 -: LUT_DEPTH] + phase_off;

    // FSM, accumulator and first valid stage. ftw_ready is updated together
    // with every state transition so it always reflects the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ftw_q       <= '0;
            shadow_q    <= '0;
            addr_q      <= '0;
            v1_q        <= 1'b0;
            wrap_q      <= 1'b0;
            running_q   <= 1'b0;
            ftw_ready_q <= 1'b1;
        end else begin
            v1_q   <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    acc_q <= '0;
                    if (accept) begin
                        ftw_q <= ftw_if.ftw_data;
                    end
                    if (enable) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    if (!enable) begin
                        state_q     <= ST_IDLE;
                        running_q   <= 1'b0;
                        ftw_ready_q <= 1'b1;
                        acc_q       <= '0;
                        // Keep a pending or just-accepted word rather than drop it.
                        if (state_q == ST_PEND) begin
                            ftw_q <= shadow_q;
                        end else if (accept) begin
                            ftw_q <= ftw_if.ftw_data;
                        end
                    end else begin
                        // The address always comes from the pre-update acc.
                        if (sample_tick) begin
                            addr_q <= tick_addr;
                            v1_q   <= 1'b1;
                        end
                        // sync_clear wins over the addition: no wrap, no commit.
                        if (sync_clear) begin
                            acc_q <= '0;
                        end else if (sample_tick) begin
                            acc_q  <= acc_sum[ACC_BITS-1:0];
                            wrap_q <= carry;
                            if (carry && (state_q == ST_PEND)) begin
                                ftw_q       <= shadow_q;
                                state_q     <= ST_RUN;
                                ftw_ready_q <= 1'b1;
                            end
                        end
                        // Only possible in RUN (ready is low in PEND); a carry on
                        // the same tick does not commit this word.
                        if (accept) begin
                            shadow_q    <= ftw_if.ftw_data;
                            state_q     <= ST_PEND;
                            ftw_ready_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    ddfs_sine_lut #(
        .LUT_DEPTH (LUT_DEPTH),
        .LUT_BITS  (LUT_BITS)
    ) u_lut (
        .clk        (clk),
        .addr       (addr_q),
        .sine_out   (lut_sine),
        .cosine_out (lut_cosine)
    );

    // Valid pipeline follows the LUT latency and keeps draining after a
    // disable; only reset discards samples in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sine_q      <= '0;
            cosine_q    <= '0;
        end else begin
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                sine_q   <= lut_sine;
                cosine_q <= lut_cosine;
            end
        end
    end

    assign ftw_if.ftw_ready = ftw_ready_q;
    assign sine_out         = sine_q;
    assign cosine_out       = cosine_q;
    assign out_valid        = out_valid_q;
    assign wrap             = wrap_q;
    assign running          = running_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_ddfs_controller.sv
// Testbench for ddfs_controller: directed scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural model with an expected queue.
module tb_ddfs_controller;
    import lockin_pkg::*;

    localparam int     AB  = 32;
    localparam int     LD  = 10;
    localparam int     LB  = 18;
    localparam longint AMP = (longint'(1) <<< (LB - 1)) - 1;
    localparam longint TOL = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst         = 1'b1;
    logic                 enable      = 1'b0;
    logic                 sample_tick = 1'b0;
    logic                 sync_clear  = 1'b0;
    logic [LD-1:0]        phase_off   = '0;
    logic signed [LB-1:0] sine_out;
    logic signed [LB-1:0] cosine_out;
    logic                 out_valid;
    logic                 wrap;
    logic                 running;
    state_t               state_dbg;

    ddfs_controller_if #(.ACC_BITS(AB)) ftw_if ();

    ddfs_controller #(
        .ACC_BITS  (AB),
        .LUT_DEPTH (LD),
        .LUT_BITS  (LB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_tick (sample_tick),
        .ftw_if      (ftw_if.slave),
        .phase_off   (phase_off),
        .sync_clear  (sync_clear),
        .sine_out    (sine_out),
        .cosine_out  (cosine_out),
        .out_valid   (out_valid),
        .wrap        (wrap),
        .running     (running),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int            err_cnt = 0;
    int            chk_cnt = 0;
    int            edge_n  = 0;
    int            wrap_seen = 0;
    int            valid_seen = 0;
    logic [LD-1:0] exp_q[$];       // LUT address of each sample in flight
    int            due_q[$];       // edge after which that sample appears
    int            wrap_due_q[$];  // edges after which wrap must be high
    longint        exp_sin = 0;
    longint        exp_cos = 0;

    // Reference model: phase generator described directly in terms of
    // accumulator value, active word, and an optional pending word.
    bit            m_run  = 1'b0;
    bit            m_pend = 1'b0;
    logic [AB-1:0] m_acc  = '0;
    logic [AB-1:0] m_ftw  = '0;
    logic [AB-1:0] m_shadow = '0;

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
        longint d;
        chk_cnt++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic longint ref_sin(input logic [LD-1:0] a);
        real ang;
        ang = 2.0 * 3.141592653589793 * real'(a) / real'(1 << LD);
        return longint'(real'(AMP) * $sin(ang));
    endfunction

    function automatic longint ref_cos(input logic [LD-1:0] a);
        real ang;
        ang = 2.0 * 3.141592653589793 * real'(a) / real'(1 << LD);
        return longint'(real'(AMP) * $cos(ang));
    endfunction

    // Advance the model over the coming rising edge using the current inputs.
    task automatic model_edge();
        bit            accept;
        bit            was_pend;
        longint        s;
        logic [LD-1:0] a;
        if (rst) begin
            m_run = 0; m_pend = 0; m_acc = '0; m_ftw = '0; m_shadow = '0;
            exp_q.delete(); due_q.delete(); wrap_due_q.delete();
            exp_sin = 0; exp_cos = 0;
            return;
        end
        accept   = ftw_if.ftw_valid && !m_pend;
        was_pend = m_pend;
        if (!m_run) begin
            m_acc = '0;
            if (accept) m_ftw = ftw_if.ftw_data;
            if (enable) m_run = 1;
        end else if (!enable) begin
            if (m_pend) m_ftw = m_shadow;
            else if (accept) m_ftw = ftw_if.ftw_data;
            m_run = 0; m_pend = 0; m_acc = '0;
        end else begin
            if (sample_tick) begin
                a = LD'((int'(m_acc >> (AB - LD)) + int'(phase_off)) % (1 << LD));
                exp_q.push_back(a);
                due_q.push_back(edge_n + 3);
            end
            if (sync_clear) begin
                m_acc = '0;
            end else if (sample_tick) begin
                s = longint'(m_acc) + longint'(m_ftw);
                m_acc = AB'(s);
                if (s >= (longint'(1) <<< AB)) begin
                    wrap_due_q.push_back(edge_n + 1);
                    if (was_pend) begin
                        m_ftw = m_shadow;
                        m_pend = 0;
                    end
                end
            end
            if (accept) begin
                m_shadow = ftw_if.ftw_data;
                m_pend = 1;
            end
        end
    endtask

    task automatic check_outputs();
        bit            ev;
        bit            wev;
        logic [LD-1:0] a;
        state_t        es;
        ev = (due_q.size() > 0) && (due_q[0] == edge_n);
        if (ev) begin
            void'(due_q.pop_front());
            a = exp_q.pop_front();
            exp_sin = ref_sin(a);
            exp_cos = ref_cos(a);
        end
        wev = (wrap_due_q.size() > 0) && (wrap_due_q[0] == edge_n);
        if (wev) void'(wrap_due_q.pop_front());
        es = m_run ? (m_pend ? ST_PEND : ST_RUN) : ST_IDLE;
        if (wrap) wrap_seen++;
        if (out_valid) valid_seen++;
        check("out_valid", longint'(out_valid), longint'(ev));
        check("sine_out", longint'(sine_out), exp_sin, TOL);
        check("cosine_out", longint'(cosine_out), exp_cos, TOL);
        check("wrap", longint'(wrap), longint'(wev));
        check("ftw_ready", longint'(ftw_if.ftw_ready), longint'(!m_pend));
        check("running", longint'(running), longint'(m_run));
        check("state", longint'(state_dbg), longint'(es));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step_cycle();
        bit hs;
        model_edge();
        hs = ftw_if.ftw_valid && ftw_if.ftw_ready;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        check_outputs();
        if (hs) ftw_if.ftw_valid = 1'b0;
    endtask

    task automatic offer(input logic [AB-1:0] w);
        ftw_if.ftw_data  = w;
        ftw_if.ftw_valid = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit toggled;
        ftw_if.ftw_valid = 1'b0;
        ftw_if.ftw_data  = '0;
        @(negedge clk);

        // Reset for 3 cycles, then ticks while idle must be ignored.
        rst = 1'b1;
        repeat (3) step_cycle();
        rst = 1'b0;
        sample_tick = 1'b1;
        repeat (5) step_cycle();
        sample_tick = 1'b0;

        // Step-1 sweep: ftw = 2^22, tick every cycle for 3072 cycles.
        offer(32'h0040_0000);
        step_cycle();
        enable = 1'b1;
        step_cycle();
        wrap_seen = 0;
        sample_tick = 1'b1;
        repeat (3072) step_cycle();
        sample_tick = 1'b0;
        repeat (4) step_cycle();
        check("sweep_wrap_count", longint'(wrap_seen), 3);

        // Phase offset: first sample from address 256 (sine peak).
        enable = 1'b0;
        step_cycle();
        phase_off = LD'(256);
        enable = 1'b1;
        step_cycle();
        sample_tick = 1'b1;
        step_cycle();
        sample_tick = 1'b0;
        repeat (4) step_cycle();
        check("phase_peak_sine", longint'(sine_out), AMP, TOL);
        check("phase_peak_cos", longint'(cosine_out), 0, TOL);

        // Phase-continuous retune from 2^22 to 2^23 with irregular ticks.
        phase_off = '0;
        sample_tick = 1'b1;
        repeat (300) step_cycle();
        offer(32'h0080_0000);
        for (int i = 0; i < 1400; i++) begin
            sample_tick = ($urandom_range(0, 3) != 0);
            step_cycle();
        end
        sample_tick = 1'b0;
        repeat (4) step_cycle();

        // sync_clear at address 500 with a concurrent tick.
        enable = 1'b0;
        step_cycle();
        offer(32'h0040_0000);
        step_cycle();
        enable = 1'b1;
        step_cycle();
        sample_tick = 1'b1;
        repeat (500) step_cycle();
        wrap_seen = 0;
        sync_clear = 1'b1;
        step_cycle();
        sync_clear = 1'b0;
        step_cycle();
        sample_tick = 1'b0;
        repeat (4) step_cycle();
        check("sync_clear_no_wrap", longint'(wrap_seen), 0);

        // Disable with two ticks in flight: exactly two more samples.
        sample_tick = 1'b1;
        repeat (2) step_cycle();
        sample_tick = 1'b0;
        enable = 1'b0;
        valid_seen = 0;
        repeat (5) step_cycle();
        check("drain_count", longint'(valid_seen), 2);
        check("drain_running", longint'(running), 0);
        // Accumulator was zeroed: next sample reads phase_off itself.
        phase_off = LD'(17);
        enable = 1'b1;
        step_cycle();
        sample_tick = 1'b1;
        step_cycle();
        sample_tick = 1'b0;
        repeat (4) step_cycle();

        // Reset one cycle after a tick: that sample never appears.
        sample_tick = 1'b1;
        step_cycle();
        sample_tick = 1'b0;
        rst = 1'b1;
        enable = 1'b0;
        step_cycle();
        rst = 1'b0;
        valid_seen = 0;
        repeat (4) step_cycle();
        check("rst_no_valid", longint'(valid_seen), 0);
        check("rst_sine", longint'(sine_out), 0);
        check("rst_state", longint'(state_dbg), longint'(ST_IDLE));

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            toggled = 1'b0;
            if (!ftw_if.ftw_valid && $urandom_range(0, 99) < 2) begin
                enable = ~enable;
                toggled = 1'b1;
            end
            sample_tick = enable && ($urandom_range(0, 1) == 1);
            sync_clear  = enable && ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) phase_off = LD'($urandom_range(0, (1 << LD) - 1));
            if (!toggled && !ftw_if.ftw_valid && $urandom_range(0, 99) < 2) begin
                if ($urandom_range(0, 9) == 0) offer('0);
                else offer(AB'($urandom_range(32'h0010_0000, 32'h0400_0000)));
            end
            step_cycle();
        end
        sample_tick = 1'b0;
        sync_clear  = 1'b0;
        repeat (5) step_cycle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
